// File: rtl/centered_check_node_admm.sv
// Check-node half of a centered ADMM LP decoder: per-edge scaled duals, bisection projection
// onto the centered parity polytope, and m = z - u messages returned to the variable nodes.
module centered_check_node_admm #(
   parameter int unsigned TAG_WIDTH      = 32,
   parameter int unsigned BLOCKLENGTH    = 3,
   parameter int unsigned DATA_WIDTH     = 15,
   parameter int unsigned FRACTION_WIDTH = DATA_WIDTH - 4,
   parameter int unsigned BISECT_ITERS   = FRACTION_WIDTH + 1
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              ready_in,
   input  logic                              valid_in,
   input  logic [TAG_WIDTH-1:0]              tag_in,
   input  logic                              clear_dual,
   input  logic [DATA_WIDTH*BLOCKLENGTH-1:0] data_in,
   output logic                              busy,
   output logic                              ready_out,
   output logic                              valid_out,
   output logic [TAG_WIDTH-1:0]              tag_out,
   output logic                              syndrome_ok,
   output logic [DATA_WIDTH*BLOCKLENGTH-1:0] data_out
);

   localparam int unsigned IW   = DATA_WIDTH + $clog2(BLOCKLENGTH) + 2;
   localparam int unsigned IDXW = $clog2(BLOCKLENGTH);
   localparam int unsigned CW   = $clog2(BISECT_ITERS + 1);
   localparam int unsigned PW   = DATA_WIDTH * BLOCKLENGTH;

   localparam logic signed [IW-1:0] HALF       = IW'(2 ** (FRACTION_WIDTH - 1));
   localparam logic signed [IW-1:0] THREE_HALF = IW'(3 * 2 ** (FRACTION_WIDTH - 1));
   localparam logic signed [IW-1:0] TWO        = IW'(2 ** (FRACTION_WIDTH + 1));
   localparam logic signed [IW-1:0] FACET_RHS  = IW'((BLOCKLENGTH - 2) * 2 ** (FRACTION_WIDTH - 1));
   localparam logic signed [IW-1:0] D_MAX      = IW'(2 ** (DATA_WIDTH - 1) - 1);
   localparam logic signed [IW-1:0] D_MIN      = IW'(-(2 ** (DATA_WIDTH - 1)));

   typedef enum logic [2:0] {S_IDLE, S_CHECK, S_BISECT, S_UPDATE, S_OUT} state_t;

   function automatic logic signed [IW-1:0] clip(input logic signed [IW-1:0] a,
                                                 input logic signed [IW-1:0] lim);
      logic signed [IW-1:0] r;
      r = a;
      if (a > lim)       r = lim;
      else if (a < -lim) r = -lim;
      return r;
   endfunction

   function automatic logic signed [DATA_WIDTH-1:0] sat_dw(input logic signed [IW-1:0] a);
      logic signed [IW-1:0] r;
      r = a;
      if (a > D_MAX)      r = D_MAX;
      else if (a < D_MIN) r = D_MIN;
      return DATA_WIDTH'(r);
   endfunction

   function automatic logic signed [IW-1:0] sext(input logic signed [DATA_WIDTH-1:0] a);
      return IW'(a);
   endfunction

   state_t                        state_q, state_d;
   logic signed [DATA_WIDTH-1:0]  x_q [BLOCKLENGTH];
   logic signed [DATA_WIDTH-1:0]  x_d [BLOCKLENGTH];
   logic signed [DATA_WIDTH-1:0]  u_q [BLOCKLENGTH];
   logic signed [DATA_WIDTH-1:0]  u_d [BLOCKLENGTH];
   logic signed [IW-1:0]          w_q [BLOCKLENGTH];
   logic signed [IW-1:0]          w_d [BLOCKLENGTH];
   logic [BLOCKLENGTH-1:0]        s_q, s_d;
   logic signed [IW-1:0]          lo_q, lo_d, hi_q, hi_d;
   logic [CW-1:0]                 cnt_q, cnt_d;
   logic [TAG_WIDTH-1:0]          tag_q, tag_d, tag_out_q, tag_out_d;
   logic [PW-1:0]                 data_out_q, data_out_d;
   logic                          valid_out_q, valid_out_d;
   logic                          ready_out_q, ready_out_d;
   logic                          busy_q, busy_d;
   logic                          syndrome_ok_q, syndrome_ok_d;

   // CHECK datapath: saturated sums, clipped point, sign vector with parity fix-up
   logic signed [IW-1:0]   w_chk [BLOCKLENGTH];
   logic signed [IW-1:0]   c_chk [BLOCKLENGTH];
   logic signed [IW-1:0]   abs_c [BLOCKLENGTH];
   logic [BLOCKLENGTH-1:0] s_raw, s_chk, x_pos;
   logic [IDXW-1:0]        min_idx;
   logic signed [IW-1:0]   facet_sum;

   always_comb begin
      s_raw     = '0;
      x_pos     = '0;
      min_idx   = '0;
      facet_sum = '0;
      for (int i = 0; i < BLOCKLENGTH; i++) begin
         w_chk[i] = clip(sext(x_q[i]) + sext(u_q[i]), THREE_HALF);
         c_chk[i] = clip(w_chk[i], HALF);
         abs_c[i] = (c_chk[i] < IW'(0)) ? -c_chk[i] : c_chk[i];
         s_raw[i] = c_chk[i] > IW'(0);
         x_pos[i] = x_q[i] > DATA_WIDTH'(0);
      end
      // strict compare keeps the lowest index on ties
      for (int i = 1; i < BLOCKLENGTH; i++) begin
         if (abs_c[i] < abs_c[min_idx]) min_idx = IDXW'(i);
      end
      s_chk = s_raw;
      if (!(^s_raw)) s_chk[min_idx] = ~s_raw[min_idx];
      for (int i = 0; i < BLOCKLENGTH; i++) begin
         facet_sum = s_chk[i] ? facet_sum + c_chk[i] : facet_sum - c_chk[i];
      end
   end

   // BISECT datapath: facet function evaluated at the interval midpoint
   logic signed [IW-1:0] mid, f_sum;
   logic                 bis_feasible;

   always_comb begin
      mid   = (lo_q + hi_q) >>> 1;
      f_sum = '0;
      for (int i = 0; i < BLOCKLENGTH; i++) begin
         if (s_q[i]) f_sum = f_sum + clip(w_q[i] - mid, HALF);
         else        f_sum = f_sum - clip(w_q[i] + mid, HALF);
      end
      bis_feasible = f_sum <= FACET_RHS;
   end

   // UPDATE datapath: hi_q holds beta (zero when the facet test passed)
   logic signed [IW-1:0]         z_upd [BLOCKLENGTH];
   logic signed [DATA_WIDTH-1:0] u_upd [BLOCKLENGTH];
   logic [PW-1:0]                m_upd;

   always_comb begin
      m_upd = '0;
      for (int i = 0; i < BLOCKLENGTH; i++) begin
         z_upd[i] = s_q[i] ? clip(w_q[i] - hi_q, HALF) : clip(w_q[i] + hi_q, HALF);
         u_upd[i] = sat_dw(sext(u_q[i]) + sext(x_q[i]) - z_upd[i]);
         m_upd[DATA_WIDTH*i +: DATA_WIDTH] = sat_dw(z_upd[i] - sext(u_upd[i]));
      end
   end

   // Next-state and register updates
   always_comb begin
      state_d       = state_q;
      x_d           = x_q;
      u_d           = u_q;
      w_d           = w_q;
      s_d           = s_q;
      lo_d          = lo_q;
      hi_d          = hi_q;
      cnt_d         = cnt_q;
      tag_d         = tag_q;
      tag_out_d     = tag_out_q;
      data_out_d    = data_out_q;
      syndrome_ok_d = syndrome_ok_q;
      valid_out_d   = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (clear_dual) begin
               for (int i = 0; i < BLOCKLENGTH; i++) u_d[i] = '0;
            end
            if (valid_in && ready_out_q) begin
               for (int i = 0; i < BLOCKLENGTH; i++) x_d[i] = data_in[DATA_WIDTH*i +: DATA_WIDTH];
               tag_d   = tag_in;
               state_d = S_CHECK;
            end
         end
         S_CHECK: begin
            w_d           = w_chk;
            s_d           = s_chk;
            syndrome_ok_d = ~^x_pos;
            if (facet_sum <= FACET_RHS) begin
               hi_d    = '0;
               state_d = S_UPDATE;
            end else begin
               lo_d    = '0;
               hi_d    = TWO;
               cnt_d   = CW'(BISECT_ITERS - 1);
               state_d = S_BISECT;
            end
         end
         S_BISECT: begin
            if (bis_feasible) hi_d = mid;
            else              lo_d = mid;
            if (cnt_q == '0) state_d = S_UPDATE;
            else             cnt_d   = cnt_q - CW'(1);
         end
         S_UPDATE: begin
            u_d        = u_upd;
            data_out_d = m_upd;
            tag_out_d  = tag_q;
            state_d    = S_OUT;
         end
         S_OUT: begin
            if (valid_out_q && ready_in) state_d = S_IDLE;
            else                         valid_out_d = 1'b1;
         end
         default: state_d = S_IDLE;
      endcase

      ready_out_d = (state_d == S_IDLE);
      busy_d      = (state_d != S_IDLE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= S_IDLE;
         for (int i = 0; i < BLOCKLENGTH; i++) begin
            x_q[i] <= '0;
            u_q[i] <= '0;
            w_q[i] <= '0;
         end
         s_q           <= '0;
         lo_q          <= '0;
         hi_q          <= '0;
         cnt_q         <= '0;
         tag_q         <= '0;
         tag_out_q     <= '0;
         data_out_q    <= '0;
         valid_out_q   <= 1'b0;
         ready_out_q   <= 1'b1;
         busy_q        <= 1'b0;
         syndrome_ok_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         x_q           <= x_d;
         u_q           <= u_d;
         w_q           <= w_d;
         s_q           <= s_d;
         lo_q          <= lo_d;
         hi_q          <= hi_d;
         cnt_q         <= cnt_d;
         tag_q         <= tag_d;
         tag_out_q     <= tag_out_d;
         data_out_q    <= data_out_d;
         valid_out_q   <= valid_out_d;
         ready_out_q   <= ready_out_d;
         busy_q        <= busy_d;
         syndrome_ok_q <= syndrome_ok_d;
      end
   end

   assign busy        = busy_q;
   assign ready_out   = ready_out_q;
   assign valid_out   = valid_out_q;
   assign tag_out     = tag_out_q;
   assign syndrome_ok = syndrome_ok_q;
   assign data_out    = data_out_q;

endmodule

// File: tb/tb_centered_check_node_admm.sv
// Directed bench for centered_check_node_admm: d=3, Q3.11 messages, hand-computed results.
module tb_centered_check_node_admm;

   localparam int DW = 15;
   localparam int BL = 3;
   localparam int PW = DW * BL;

   logic          clk = 1'b0;
   logic          reset, ready_in, valid_in, clear_dual;
   logic [31:0]   tag_in, tag_out;
   logic [PW-1:0] data_in, data_out;
   logic          busy, ready_out, valid_out, syndrome_ok;

   int checks = 0;
   int errors = 0;

   centered_check_node_admm #(
      .TAG_WIDTH(32), .BLOCKLENGTH(3), .DATA_WIDTH(15), .FRACTION_WIDTH(11), .BISECT_ITERS(12)
   ) dut (
      .clk(clk), .reset(reset), .ready_in(ready_in), .valid_in(valid_in), .tag_in(tag_in),
      .clear_dual(clear_dual), .data_in(data_in), .busy(busy), .ready_out(ready_out),
      .valid_out(valid_out), .tag_out(tag_out), .syndrome_ok(syndrome_ok), .data_out(data_out)
   );

   always #5 clk = ~clk;

   function automatic logic [PW-1:0] pack3(input int a, input int b, input int c);
      logic [DW-1:0] ea, eb, ec;
      ea = DW'(a);
      eb = DW'(b);
      ec = DW'(c);
      return {ec, eb, ea};
   endfunction

   function automatic int elem(input logic [PW-1:0] v, input int i);
      logic signed [DW-1:0] t;
      t = v[DW*i +: DW];
      return int'(t);
   endfunction

   // One-cycle clear_dual pulse while idle
   task automatic pulse_clear();
      clear_dual = 1'b1;
      @(posedge clk); #1;
      clear_dual = 1'b0;
   endtask

   // Accept one vector and wait (bounded) for valid_out; lat = edges from accept to valid_out
   task automatic run_vector(input int a, input int b, input int c, input logic [31:0] tag,
                             input bit clr_acc, input bit clr_busy, output int lat);
      int guard;
      guard = 0;
      while (!ready_out && guard < 50) begin
         @(posedge clk); #1;
         guard++;
      end
      data_in    = pack3(a, b, c);
      tag_in     = tag;
      valid_in   = 1'b1;
      clear_dual = clr_acc;
      @(posedge clk); #1;
      valid_in   = 1'b0;
      clear_dual = 1'b0;
      data_in    = '0;
      lat = 0;
      while (!valid_out && lat < 60) begin
         clear_dual = clr_busy && (lat == 4);
         @(posedge clk); #1;
         lat++;
      end
      clear_dual = 1'b0;
   endtask

   task automatic release_out();
      ready_in = 1'b1;
      @(posedge clk); #1;
      ready_in = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; ready_in = 1'b0; valid_in = 1'b0; clear_dual = 1'b0;
      tag_in = '0; data_in = '0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({valid_out, busy, ready_out, syndrome_ok} !== 4'b0010) begin
         errors++;
         $display("FAIL reset_flags got v/b/r/s=%b want 0010", {valid_out, busy, ready_out, syndrome_ok});
      end
      checks++;
      if (data_out !== '0) begin
         errors++;
         $display("FAIL reset_data_out got %h want 0", data_out);
      end
      checks++;
      if (tag_out !== '0) begin
         errors++;
         $display("FAIL reset_tag_out got %h want 0", tag_out);
      end
      reset = 1'b0;
      @(posedge clk); #1;
      checks++;
      if ({ready_out, busy} !== 2'b10) begin
         errors++;
         $display("FAIL reset_release_idle got r/b=%b want 10", {ready_out, busy});
      end
   endtask

   task automatic test_vertex();
      int lat;
      pulse_clear();
      run_vector(-1024, -1024, -1024, 32'h0000_00A1, 1'b0, 1'b0, lat);
      checks++;
      if (lat != 3) begin
         errors++;
         $display("FAIL vertex_latency got %0d want 3", lat);
      end
      checks++;
      if (data_out !== pack3(-1024, -1024, -1024)) begin
         errors++;
         $display("FAIL vertex_m got %0d,%0d,%0d want -1024,-1024,-1024",
                  elem(data_out, 0), elem(data_out, 1), elem(data_out, 2));
      end
      checks++;
      if ({syndrome_ok, tag_out} !== {1'b1, 32'h0000_00A1}) begin
         errors++;
         $display("FAIL vertex_synd_tag got %b/%h want 1/000000a1", syndrome_ok, tag_out);
      end
      checks++;
      if ({ready_out, busy} !== 2'b01) begin
         errors++;
         $display("FAIL vertex_out_flags got r/b=%b want 01", {ready_out, busy});
      end
      release_out();
      checks++;
      if ({valid_out, ready_out, busy} !== 3'b010) begin
         errors++;
         $display("FAIL vertex_handshake got v/r/b=%b want 010", {valid_out, ready_out, busy});
      end
   endtask

   task automatic test_bisect();
      int lat;
      pulse_clear();
      run_vector(1024, 1024, 1024, 32'h0000_00B2, 1'b0, 1'b0, lat);
      checks++;
      if (lat != 15) begin
         errors++;
         $display("FAIL bisect_latency got %0d want 15", lat);
      end
      for (int i = 0; i < BL; i++) begin
         checks++;
         if (elem(data_out, i) < -343 || elem(data_out, i) > -339) begin
            errors++;
            $display("FAIL bisect_m%0d got %0d want -341+-2", i, elem(data_out, i));
         end
      end
      checks++;
      if (syndrome_ok !== 1'b0) begin
         errors++;
         $display("FAIL bisect_syndrome got %b want 0", syndrome_ok);
      end
      release_out();
   endtask

   task automatic test_dual_persist();
      int lat;
      // clear_dual pulsed mid-bisection must be ignored
      run_vector(1024, 1024, 1024, 32'h0000_00C3, 1'b0, 1'b1, lat);
      checks++;
      if (lat != 15) begin
         errors++;
         $display("FAIL persist_latency got %0d want 15", lat);
      end
      for (int i = 0; i < BL; i++) begin
         checks++;
         if (elem(data_out, i) < -1026 || elem(data_out, i) > -1022) begin
            errors++;
            $display("FAIL persist_m%0d got %0d want -1024+-2", i, elem(data_out, i));
         end
      end
      release_out();
      run_vector(1024, 1024, 1024, 32'h0000_00C4, 1'b1, 1'b0, lat);
      for (int i = 0; i < BL; i++) begin
         checks++;
         if (elem(data_out, i) < -343 || elem(data_out, i) > -339) begin
            errors++;
            $display("FAIL cleared_m%0d got %0d want -341+-2", i, elem(data_out, i));
         end
      end
      release_out();
   endtask

   task automatic test_backpressure();
      int lat;
      logic [PW-1:0] exp_m;
      exp_m = pack3(-1024, -1024, -1024);
      run_vector(-1024, -1024, -1024, 32'hDEAD_BEEF, 1'b1, 1'b0, lat);
      checks++;
      if (lat != 3) begin
         errors++;
         $display("FAIL stall_latency got %0d want 3", lat);
      end
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         checks++;
         if ({valid_out, ready_out, busy, syndrome_ok, tag_out, data_out} !==
             {1'b1, 1'b0, 1'b1, 1'b1, 32'hDEAD_BEEF, exp_m}) begin
            errors++;
            $display("FAIL stall_hold%0d got v/r/b/s=%b tag=%h data=%h want 1011 deadbeef %h",
                     k, {valid_out, ready_out, busy, syndrome_ok}, tag_out, data_out, exp_m);
         end
      end
      release_out();
      checks++;
      if ({valid_out, ready_out, busy} !== 3'b010) begin
         errors++;
         $display("FAIL stall_release got v/r/b=%b want 010", {valid_out, ready_out, busy});
      end
   endtask

   task automatic test_reset_mid_bisect();
      int lat;
      int guard;
      run_vector(1024, 1024, 1024, 32'h0000_00E5, 1'b0, 1'b0, lat);
      release_out();
      guard = 0;
      while (!ready_out && guard < 50) begin
         @(posedge clk); #1;
         guard++;
      end
      data_in = pack3(1024, 1024, 1024);
      tag_in  = 32'h0000_00E6;
      valid_in = 1'b1;
      @(posedge clk); #1;
      valid_in = 1'b0;
      repeat (6) @(posedge clk);
      #2;
      reset = 1'b1;
      #1;
      checks++;
      if ({valid_out, ready_out, busy} !== 3'b010) begin
         errors++;
         $display("FAIL midreset_flags got v/r/b=%b want 010", {valid_out, ready_out, busy});
      end
      @(posedge clk); #1;
      reset = 1'b0;
      run_vector(-1024, -1024, -1024, 32'h0000_00E7, 1'b0, 1'b0, lat);
      checks++;
      if (lat != 3) begin
         errors++;
         $display("FAIL midreset_latency got %0d want 3", lat);
      end
      checks++;
      if ({syndrome_ok, data_out} !== {1'b1, pack3(-1024, -1024, -1024)}) begin
         errors++;
         $display("FAIL midreset_result got s=%b m=%0d,%0d,%0d want 1 -1024,-1024,-1024", syndrome_ok,
                  elem(data_out, 0), elem(data_out, 1), elem(data_out, 2));
      end
      release_out();
   endtask

   task automatic test_facet_equality();
      int lat;
      pulse_clear();
      run_vector(-512, 512, 1024, 32'h0000_00F6, 1'b0, 1'b0, lat);
      checks++;
      if (lat != 3) begin
         errors++;
         $display("FAIL equality_latency got %0d want 3", lat);
      end
      checks++;
      if ({syndrome_ok, data_out} !== {1'b1, pack3(-512, 512, 1024)}) begin
         errors++;
         $display("FAIL equality_result got s=%b m=%0d,%0d,%0d want 1 -512,512,1024", syndrome_ok,
                  elem(data_out, 0), elem(data_out, 1), elem(data_out, 2));
      end
      release_out();
   endtask

   // Accept directly after a handshake; duals are still zero so results repeat
   task automatic test_back_to_back();
      int lat;
      run_vector(-512, 512, 1024, 32'h0000_00F7, 1'b0, 1'b0, lat);
      checks++;
      if (lat != 3) begin
         errors++;
         $display("FAIL b2b_latency got %0d want 3", lat);
      end
      checks++;
      if ({tag_out, data_out} !== {32'h0000_00F7, pack3(-512, 512, 1024)}) begin
         errors++;
         $display("FAIL b2b_result got tag=%h data=%h want 000000f7 %h", tag_out, data_out,
                  pack3(-512, 512, 1024));
      end
      release_out();
   endtask

   initial begin
      test_reset();
      test_vertex();
      test_bisect();
      test_dual_persist();
      test_backpressure();
      test_reset_mid_bisect();
      test_facet_equality();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got timeout want completion");
      $fatal(1, "watchdog expired");
   end

endmodule
